// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width, opcodes and flag bundle
// Purpose: common definitions for alu4_core and alu_arbiter.
// Ports: none (package).
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_LT  = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic out;
  } alu_flags_t;

endpackage

// File: rtl/alu4_core.sv
// rtl/alu4_core.sv - purely combinational 4-bit ALU
// Purpose: computes result and flags for one operation.
// Ports:
//   a, b    in  ALU_W  operands (signed for LT/overflow)
//   func    in  3      opcode (ALU_ADD..ALU_EQ)
//   result  out ALU_W  result
//   flags   out        {carry, overflow, zero, out}
module alu4_core
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [2:0]       func,
  output logic [ALU_W-1:0] result,
  output alu_flags_t       flags
);

  logic [ALU_W-1:0] b_eff;
  logic             cin;
  logic [ALU_W:0]   sum;
  logic             cmp;

  // One shared adder: subtraction is A + ~B + 1, so carry=1 means no borrow.
  always_comb begin
    b_eff = (func == ALU_SUB) ? ~b : b;
    cin   = (func == ALU_SUB);
    sum   = {1'b0, a} + {1'b0, b_eff} + {{ALU_W{1'b0}}, cin};
  end

  always_comb begin
    result = '0;
    flags  = '0;
    cmp    = 1'b0;
    case (func)
      ALU_ADD, ALU_SUB: begin
        result         = sum[ALU_W-1:0];
        flags.carry    = sum[ALU_W];
        flags.overflow = (a[ALU_W-1] == b_eff[ALU_W-1]) &&
                         (sum[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_NOT: result = ~a;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_LT: begin
        cmp    = $signed(a) < $signed(b);
        result = {{(ALU_W-1){1'b0}}, cmp};
      end
      ALU_EQ: begin
        cmp    = (a == b);
        result = {{(ALU_W-1){1'b0}}, cmp};
      end
      default: ;
    endcase
    flags.out  = cmp;
    flags.zero = ~|result;
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters
// Purpose: grants one request per cycle (round-robin on contention), computes
//   it in the same cycle and holds the result in a one-entry response register.
// Optional: define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   reqN_valid/ready                request handshake, N = 0,1
//   reqN_a, reqN_b, reqN_func       operands and opcode
//   rsp_valid/ready                 response handshake
//   rsp_id, rsp_result              granted requester index, result
//   rsp_carry/overflow/zero/out     flags
//   grant_cnt0/1 (stats only)       8-bit saturating grant counters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_func,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_func,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_overflow,
  output logic         rsp_zero,
  output logic         rsp_out
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]   grant_cnt0,
  output logic [7:0]   grant_cnt1
`endif
);

  logic         prio;
  logic         free;
  logic         grant0;
  logic         grant1;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [2:0]   sel_func;
  logic [W-1:0] alu_result;
  alu_flags_t   alu_flags;

  // The register can accept a new result when empty or draining this cycle.
  // Grants depend only on valids, prio and free, never on a ready itself.
  always_comb begin
    free       = !rsp_valid || rsp_ready;
    grant0     = rst_n && free && req0_valid && (!req1_valid || !prio);
    grant1     = rst_n && free && req1_valid && (!req0_valid ||  prio);
    req0_ready = grant0;
    req1_ready = grant1;
    sel_a      = grant1 ? req1_a    : req0_a;
    sel_b      = grant1 ? req1_b    : req0_b;
    sel_func   = grant1 ? req1_func : req0_func;
  end

  alu4_core u_core (
    .a      (sel_a),
    .b      (sel_b),
    .func   (sel_func),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_out      <= 1'b0;
    end else if (grant0 || grant1) begin
      // Priority moves to whichever requester lost this cycle.
      prio         <= grant0;
      rsp_valid    <= 1'b1;
      rsp_id       <= grant1;
      rsp_result   <= alu_result;
      rsp_carry    <= alu_flags.carry;
      rsp_overflow <= alu_flags.overflow;
      rsp_zero     <= alu_flags.zero;
      rsp_out      <= alu_flags.out;
    end else if (rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0 <= 8'd0;
      grant_cnt1 <= 8'd0;
    end else begin
      if (grant0 && (grant_cnt0 != 8'hFF)) grant_cnt0 <= grant_cnt0 + 8'd1;
      if (grant1 && (grant_cnt1 != 8'hFF)) grant_cnt1 <= grant_cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard testbench for alu_arbiter
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic       id;
    logic [3:0] result;
    logic       c;
    logic       o;
    logic       z;
    logic       out;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_func, req1_func;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_result;
  logic       rsp_carry, rsp_overflow, rsp_zero, rsp_out;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_func    (req0_func),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_func    (req1_func),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .rsp_out      (rsp_out)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1)
`endif
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  rsp_t scb[$];
  logic m_valid = 1'b0;
  logic m_prio  = 1'b0;
  logic g0_n    = 1'b0;
  logic g1_n    = 1'b0;
  logic after_reset = 1'b0;
  logic e0, e1, m_free;
  rsp_t act_r;
  logic [8:0] snap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from signed/unsigned integer arithmetic.
  function automatic rsp_t model(input logic id, input logic [3:0] a, input logic [3:0] b,
                                 input logic [2:0] f);
    rsp_t m;
    int ua, ub, sa, sb, r;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    r  = 0;
    m  = '0;
    m.id = id;
    case (f)
      3'd0: begin r = ua + ub; m.c = (r >= 16); m.o = (sa + sb > 7) || (sa + sb < -8); end
      3'd1: begin r = ua - ub; m.c = (ua >= ub); m.o = (sa - sb > 7) || (sa - sb < -8); end
      3'd2: r = 15 - ua;
      3'd3: r = ua & ub;
      3'd4: r = ua | ub;
      3'd5: r = ua ^ ub;
      3'd6: begin m.out = (sa < sb); r = m.out ? 1 : 0; end
      3'd7: begin m.out = (ua == ub); r = m.out ? 1 : 0; end
    endcase
    m.result = r[3:0];
    m.z = (m.result == 4'd0);
    return m;
  endfunction

  // Monitor / scoreboard: arbitration predicted from its rules, responses
  // compared against the queue head every cycle the register is full.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_readies", 32'({req0_ready, req1_ready}), 32'd0);
        m_valid = 1'b0;
        m_prio  = 1'b0;
        g0_n    = 1'b0;
        g1_n    = 1'b0;
        scb.delete();
        after_reset = 1'b1;
      end else begin
        if (after_reset) begin
          chk("reset_outputs", 32'({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow,
                                    rsp_zero, rsp_out}), 32'd0);
          after_reset = 1'b0;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        m_free = !m_valid || rsp_ready;
        e0 = m_free && req0_valid && (!req1_valid || !m_prio);
        e1 = m_free && req1_valid && (!req0_valid ||  m_prio);
        chk("readies", 32'({req0_ready, req1_ready}), 32'({e0, e1}));
        if (m_valid) begin
          act_r = {rsp_id, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_out};
          if (scb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got %0h expected none", act_r);
          end else begin
            chk("rsp_data", 32'(act_r), 32'(scb[0]));
            if (rsp_ready) void'(scb.pop_front());
          end
        end
        if (e0 || e1) begin
          scb.push_back(model(e1, e1 ? req1_a : req0_a, e1 ? req1_b : req0_b,
                              e1 ? req1_func : req0_func));
          m_prio  = e0;
          m_valid = 1'b1;
        end else if (rsp_ready) begin
          m_valid = 1'b0;
        end
        g0_n = e0;
        g1_n = e1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] f);
    if (n == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_func = f;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_func = f;
    end
  endtask

  task automatic one(input int n, input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
    set_req(n, 1'b1, a, b, f);
    tick();
    set_req(n, 1'b0, a, b, f);
  endtask

  task automatic expect_rsp(input string name, input logic id, input logic [3:0] res,
                            input logic c, input logic o, input logic z, input logic out);
    @(negedge clk);
    chk(name, 32'({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_out}),
        32'({1'b1, id, res, c, o, z, out}));
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 1'b0, 4'd0, 4'd0, 3'd0);
    set_req(1, 1'b0, 4'd0, 4'd0, 3'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed arithmetic and logic cases.
    one(0, 4'd3, 4'd4, ALU_ADD);  expect_rsp("add_3_4",   1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    one(1, 4'd7, 4'd1, ALU_ADD);  expect_rsp("add_ovf",   1'b1, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    one(1, 4'd8, 4'd1, ALU_SUB);  expect_rsp("sub_ovf",   1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    one(0, 4'd14, 4'd1, ALU_LT);  expect_rsp("lt_neg",    1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    one(0, 4'd5, 4'd5, ALU_EQ);   expect_rsp("eq_5_5",    1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    one(0, 4'd5, 4'd2, ALU_AND);  expect_rsp("and_zero",  1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Fairness from reset: both valid -> 0,1,0,1, then req1 alone.
    do_reset();
    set_req(0, 1'b1, 4'd1, 4'd2, ALU_ADD);
    set_req(1, 1'b1, 4'd6, 4'd3, ALU_XOR);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fair_alternate", 32'({req0_ready, req1_ready}), (i % 2 == 0) ? 32'd2 : 32'd1);
      tick();
    end
    req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("req1_alone", 32'({req0_ready, req1_ready}), 32'd1);
      tick();
    end

    // Backpressure with a pending response and both requesters valid.
    rsp_ready  = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_readies", 32'({req0_ready, req1_ready}), 32'd0);
      if (i == 0) snap = {rsp_id, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_out};
      else chk("stall_stable", 32'({rsp_id, rsp_result, rsp_carry, rsp_overflow, rsp_zero,
                                    rsp_out}), 32'(snap));
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("drain_grant", 32'({rsp_valid, req0_ready, req1_ready}), 32'b110);
    tick();
    set_req(0, 1'b0, 4'd0, 4'd0, 3'd0);
    set_req(1, 1'b0, 4'd0, 4'd0, 3'd0);
    @(negedge clk);
    chk("valid_after_drain_grant", 32'(rsp_valid), 32'd1);
    tick();
    tick();

    // Reset while a response is held.
    one(0, 4'd2, 4'd2, ALU_OR);
    rsp_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("reset_discards", 32'(rsp_valid), 32'd0);
    tick();

    // Long req0-only run (saturates the counter when stats are enabled).
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      set_req(0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)));
      tick();
`ifdef ALU_ARB_STATS_EN
      if (i == 100) chk("grant_cnt0_100", 32'(grant_cnt0), 32'd100);
`endif
    end
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0_sat", 32'(grant_cnt0), 32'd255);
    chk("grant_cnt1_zero", 32'(grant_cnt1), 32'd0);
`endif
    req0_valid = 1'b0;

    // Randomized traffic; operands only change once accepted.
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || g0_n)
        set_req(0, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      if (!req1_valid || g1_n)
        set_req(1, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      rsp_ready = 1'($urandom_range(0, 3) != 0);
      tick();
    end

    // Requesters may only drop valid once their pending op was accepted.
    for (int i = 0; i < 20; i++) begin
      if (g0_n) req0_valid = 1'b0;
      if (g1_n) req1_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    chk("scoreboard_drained", 32'(scb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 4-bit combinational ALU between two requesters. Requests use valid/ready handshakes, and grants alternate round-robin. Each granted operation is computed in the same cycle and held in a one-entry response register until the consumer accepts it. The block sits between the NPC issue logic and the ALU, replacing direct ALU wiring wherever two sources contend for it.

## Interface
Parameters:
- `W`, default 4: operand/result width. The only supported value is 4.

Ports (the clock is `clk`; reset is `rst_n`, synchronous and active-low):
- `clk`  in  1  clock, all state updates on the rising edge
- `rst_n`  in  1  synchronous active-low reset
- `req0_valid` / `req1_valid`  in  1  requester has an operation
- `req0_ready` / `req1_ready`  out  1  operation accepted this cycle (grant)
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  W  signed operands
- `req0_func` / `req1_func`  in  3  opcode
- `rsp_valid`  out  1  response register holds a result
- `rsp_ready`  in  1  consumer takes the response
- `rsp_id`  out  1  requester index of the held response
- `rsp_result`  out  W  result
- `rsp_carry`, `rsp_overflow`, `rsp_zero`, `rsp_out`  out  1 each  flags

## Operation
Opcodes:
- 000: add, A+B
- 001: sub, A+~B+1
- 010: ~A
- 011: A&B
- 100: A|B
- 101: A^B
- 110: signed A<B
- 111: A==B

Flags:
- `carry`: the 5th bit of the adder sum. For sub, carry=1 means there was no borrow.
- `overflow`: (A[3]==B'[3]) && (R[3]!=A[3]), where B' is the effective adder operand (B for add, ~B for sub).
- For opcodes 010–111, carry and overflow are 0.
- `zero`: always ~|result.
- Opcodes 110/111: `out` is the compare bit and result = {3'b000, out}. For all other opcodes, `out` = 0.
- Every output is fully defined. There are no latches and no held-over values.

Arbitration:
- `free` = !rsp_valid || rsp_ready.
- With only one requester valid and `free`, that requester is granted.
- With both valid and `free`, the requester named by pointer `prio` is granted.
- After any grant, `prio` points to the requester that was not granted.
- When `free` = 0, neither ready is asserted and `prio` is unchanged.
- `reqN_ready` is a combinational function of the valids, `prio` and `free`. It never depends on that requester's own ready, and at most one ready is high per cycle.

Response register:
- On a grant, the register loads the ALU output, the flags and `rsp_id`, and sets `rsp_valid`.
- If the register is drained with no grant in the same cycle, `rsp_valid` is cleared.
- A drain and a grant in the same cycle load the new result, and `rsp_valid` stays 1.
- While `rsp_valid`=1 && `rsp_ready`=0, all `rsp_*` outputs are held stable.
- Requesters must hold operands stable while valid and not ready. The arbiter does not check this.

## Timing
- Reset, on the edge with `rst_n`=0:
  - `rsp_valid`=0; `rsp_id`, `rsp_result` and all flags are 0; `prio`=0.
  - Both readies are 0 during reset.
  - A held response is discarded, not delivered.
- Latency: grant in cycle N gives `rsp_valid` in cycle N+1.
- Throughput: one operation per cycle while `rsp_ready`=1.
- Backpressure: the cycle after `rsp_ready` drops with `rsp_valid`=1, no grants are issued until the register drains.
- Fairness: with both requesters continuously valid and `rsp_ready`=1, grants alternate 0,1,0,1 starting from `prio` after reset (0).
- Reset asserted while `rsp_valid`=1 and `rsp_ready`=0: the response is lost and `rsp_valid`=0 on the next cycle.

## Configuration
- `ALU_ARB_STATS_EN` defined: adds the following ports.
  - `grant_cnt0` and `grant_cnt1`, out, 8 bits each: per-requester grant counters.
  - Each counter increments on its requester's grant and saturates at 255.
  - Both counters are cleared by reset.
- `ALU_ARB_STATS_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Package `alu_pkg`:
  - opcode localparams `ALU_ADD`..`ALU_EQ`
  - `ALU_W`=4
  - packed flag typedef `alu_flags_t` {carry, overflow, zero, out}
- Sub-module `alu4_core`: purely combinational, (a, b, func) -> (result, flags). It implements the opcode and flag rules above.
- Arbitration logic, `prio`, the response register and the optional counters live in `alu_arbiter`.

## Test plan
- Reset, then req0 add a=3, b=4 with rsp_ready=1 -> next cycle `rsp_valid`=1, id=0, result=7, carry=0, overflow=0, zero=0.
- req1 add a=7, b=1 -> result=-8 (4'b1000), overflow=1, carry=0. Then req1 sub a=-8, b=1 -> result=7, overflow=1, carry=1.
- Both requesters valid for 4 cycles with rsp_ready=1 -> ids 0,1,0,1. Drop req0 -> req1 granted every cycle.
- Hold rsp_ready=0 with a response pending and both requesters valid for 3 cycles -> readies stay 0 and `rsp_*` stay stable. Raise rsp_ready -> drain and a new grant in the same cycle, `rsp_valid` stays 1.
- req0 lt a=-2, b=1 -> out=1, result=1. req0 eq a=5, b=5 -> out=1. req0 and a=5, b=2 -> result=0, zero=1, out=0.
- Assert `rst_n`=0 with a response held -> `rsp_valid`=0 next cycle. With `ALU_ARB_STATS_EN`: 300 grants to req0 -> `grant_cnt0`=255.
